wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 28 ++
 rtl/wb_stage_ld_ext.sv | 34 +++
 rtl/wb_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared encodings and the W pipeline register layout for the writeback stage.
package wb_stage_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC8  = 2'd2;
  localparam logic [1:0] WB_AUX  = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [1:0]  addr;
    logic [4:0]  a3;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [31:0] aux;
    logic [2:0]  ld_op;
  } w_reg_t;

endpackage

// File: rtl/wb_stage_ld_ext.sv
// Load data extraction: picks the addressed byte/half of an aligned word and extends it.
module ld_ext
  import wb_stage_pkg::*;
(
  input  logic [31:0] Word,
  input  logic [1:0]  Addr,
  input  logic [2:0]  LdOp,
  output logic [31:0] Data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = Word[7:0];
    case (Addr)
      2'd1:    byte_sel = Word[15:8];
      2'd2:    byte_sel = Word[23:16];
      2'd3:    byte_sel = Word[31:24];
      default: byte_sel = Word[7:0];
    endcase
    half_sel = Addr[1] ? Word[31:16] : Word[15:0];

    // Unused opcodes fall through to a plain word load.
    case (LdOp)
      LD_LBU:  Data = {24'b0, byte_sel};
      LD_LB:   Data = {{24{byte_sel[7]}}, byte_sel};
      LD_LHU:  Data = {16'b0, half_sel};
      LD_LH:   Data = {{16{half_sel[15]}}, half_sel};
      default: Data = Word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: W pipeline register, GRF write-data mux and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_M,
  input  logic        valid_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALU_M,
  input  logic [31:0] DM_M,
  input  logic [1:0]  Addr_M,
  input  logic [4:0]  A3_M,
  input  logic        RegWE_M,
  input  logic [1:0]  WBSel_M,
  input  logic [31:0] Aux_M,
  input  logic [2:0]  LdOp_M,
  output logic [4:0]  GRF_A3,
  output logic [31:0] GRF_WD,
  output logic        GRF_WE,
  output logic [31:0] PC_W,
  output logic        AlignErr_W,
  output logic [31:0] Retired
);

  w_reg_t      w_q;
  logic [31:0] retired_q;
  logic [31:0] load_data;
  logic        is_half;
  logic        is_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= '0;
    end else begin
      w_q.valid  <= valid_M & ~flush_M;
      w_q.pc     <= PC_M;
      w_q.alu    <= ALU_M;
      w_q.dm     <= DM_M;
      w_q.addr   <= Addr_M;
      w_q.a3     <= A3_M;
      w_q.reg_we <= RegWE_M;
      w_q.wb_sel <= WBSel_M;
      w_q.aux    <= Aux_M;
      w_q.ld_op  <= LdOp_M;
    end
  end

  ld_ext u_ld_ext (
    .Word (w_q.dm),
    .Addr (w_q.addr),
    .LdOp (w_q.ld_op),
    .Data (load_data)
  );

  assign is_half = (w_q.ld_op == LD_LHU) || (w_q.ld_op == LD_LH);
  assign is_word = !is_half && (w_q.ld_op != LD_LBU) && (w_q.ld_op != LD_LB);

  assign AlignErr_W = w_q.valid && (w_q.wb_sel == WB_LOAD) &&
                      ((is_word && (w_q.addr != 2'd0)) || (is_half && w_q.addr[0]));

  assign GRF_WE = w_q.valid && w_q.reg_we && (w_q.a3 != 5'd0) && !AlignErr_W;
  // Bubbles present address 0 so the forwarding comparators never match them.
  assign GRF_A3 = GRF_WE ? w_q.a3 : 5'd0;
  assign PC_W   = w_q.pc;

  always_comb begin
    GRF_WD = w_q.alu;
    case (w_q.wb_sel)
      WB_LOAD: GRF_WD = load_data;
      WB_PC8:  GRF_WD = w_q.pc + 32'd8;
      WB_AUX:  GRF_WD = w_q.aux;
      default: GRF_WD = w_q.alu;
    endcase
  end

  // The W instruction retires on the edge that moves it out of W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (w_q.valid && !AlignErr_W) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign Retired = retired_q;

endmodule
